// File: rtl/clock_display_if.sv
// Display-side bundle between the clock counter and the 7-segment scan driver.
// The master side drives time of day; the slave side drives the board pins.
interface clock_display_if;
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame;
    logic       bcd_err;

    modport master (
        output pm, hh, mm, ss,
        input  seg, dp, an, frame, bcd_err
    );

    modport slave (
        input  pm, hh, mm, ss,
        output seg, dp, an, frame, bcd_err
    );
endinterface

// File: rtl/clock_display_driver.sv
// Six-digit multiplexed 7-segment driver for the time-of-day display.
// A coherent snapshot of {pm,hh,mm,ss} is taken once per scan frame, then
// one digit per slot is decoded and driven with a short all-dark blanking
// window at the start of every slot.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_LOAD | first cycle out of reset: take the first snapshot, hold scan
// ST_SCAN | free-running scan; snapshot again on every frame wrap
module clock_display_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 100,
    parameter bit BLANK_LZ  = 1'b1
) (
    input logic            clk,
    input logic            reset,
    clock_display_if.slave bus
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_PRE = PRE_W'(BLANK_CYC);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [PRE_W-1:0] pre;
    logic [2:0]       idx;
    logic             step;
    logic             advance;
    logic             load;

    logic             pm_s;
    logic [7:0]       hh_s;
    logic [7:0]       mm_s;
    logic [7:0]       ss_s;

    logic [3:0]       nib;
    logic [6:0]       seg_on;
    logic             dp_on;
    logic             lz_blank;
    logic [5:0]       an_nxt;
    logic             snap_bad;

    logic [6:0]       seg_q;
    logic             dp_q;
    logic [5:0]       an_q;
    logic             frame_q;
    logic             bcd_err_q;

    // Active-high gfedcba pattern; anything outside 0..9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    function automatic logic byte_bad(input logic [7:0] value);
        return (value[3:0] > 4'd9) || (value[7:4] > 4'd9);
    endfunction

    assign step = (pre == PRE_LAST);

    // State register for the load/scan sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer: the load cycle holds the prescaler so the first frame after
    // reset starts cleanly at slot 0 with the fresh snapshot already in place.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                advance = 1'b1;
                if (step && (idx == 3'd5)) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            idx <= 3'd0;
        end else if (advance) begin
            if (step) begin
                pre <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign snap_bad = byte_bad(bus.hh) || byte_bad(bus.mm) || byte_bad(bus.ss);

    // Snapshot shadow, frame pulse and sticky BCD error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pm_s      <= 1'b0;
            hh_s      <= 8'h00;
            mm_s      <= 8'h00;
            ss_s      <= 8'h00;
            frame_q   <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            frame_q <= load;
            if (load) begin
                pm_s <= bus.pm;
                hh_s <= bus.hh;
                mm_s <= bus.mm;
                ss_s <= bus.ss;
                if (snap_bad) begin
                    bcd_err_q <= 1'b1;
                end
            end
        end
    end

    // Pick the nibble for the current slot.
    always_comb begin
        nib = 4'd0;
        case (idx)
            3'd0:    nib = ss_s[3:0];
            3'd1:    nib = ss_s[7:4];
            3'd2:    nib = mm_s[3:0];
            3'd3:    nib = mm_s[7:4];
            3'd4:    nib = hh_s[3:0];
            3'd5:    nib = hh_s[7:4];
            default: nib = 4'd0;
        endcase
    end

    assign seg_on = seg_decode(nib);

    // Decimal point: PM marker on slot 0, 1 Hz colon blink on slots 2 and 4.
    always_comb begin
        dp_on = 1'b0;
        case (idx)
            3'd0:       dp_on = pm_s;
            3'd2, 3'd4: dp_on = ~ss_s[0];
            default:    dp_on = 1'b0;
        endcase
    end

    assign lz_blank = BLANK_LZ && (hh_s[7:4] == 4'd0);

    // Anode select: dark during the blanking window and for a blanked leading zero.
    always_comb begin
        an_nxt = 6'h3F;
        if ((pre >= BLANK_PRE) && !((idx == 3'd5) && lz_blank)) begin
            an_nxt = ~(6'd1 << idx);
        end
    end

    // Pin registers; segment data only moves at slot boundaries where pre=0,
    // which is inside the blanking window.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= 6'h3F;
        end else begin
            seg_q <= ~seg_on;
            dp_q  <= ~dp_on;
            an_q  <= an_nxt;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.an      = an_q;
    assign bus.frame   = frame_q;
    assign bus.bcd_err = bcd_err_q;

endmodule
